// File: rtl/ysyx_220066_wb_arbiter.sv
// rtl/ysyx_220066_wb_arbiter.sv - register file write port arbiter with mul/div scoreboard
module ysyx_220066_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wen,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            iss_valid,
  input  logic            iss_unit,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic            mul_valid,
  input  logic [4:0]      mul_rd,
  input  logic [XLEN-1:0] mul_result,
  output logic            mul_ready,
  input  logic            div_valid,
  input  logic [4:0]      div_rd,
  input  logic [XLEN-1:0] div_result,
  output logic            div_ready,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [31:0]     busy_mask,
  output logic            stall_req
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic            mul_full, div_full;
  logic [4:0]      mul_rd_q, div_rd_q;
  logic [XLEN-1:0] mul_data_q, div_data_q;
  logic [1:0]      unit_busy;
  logic            rr;                 // 0 = multiplier preferred on contention
  logic [CW-1:0]   mul_cnt, div_cnt;

  logic            grant_mul, grant_div;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [CW-1:0]   mul_cnt_nxt, div_cnt_nxt;
  logic [31:0]     busy_nxt;
  logic [1:0]      unit_busy_nxt;
  logic            iss_fire;

  assign mul_ready = !mul_full;
  assign div_ready = !div_full;
  assign iss_ready = !unit_busy[iss_unit] && !busy_mask[iss_rd];
  assign iss_fire  = iss_valid && iss_ready;

  // Pick the source of next edge's write: pipeline first, then lone buffer, then round robin
  always_comb begin
    grant_mul = 1'b0;
    grant_div = 1'b0;
    if (!pipe_wen) begin
      if (mul_full && div_full) begin
        grant_mul = !rr;
        grant_div = rr;
      end else begin
        grant_mul = mul_full;
        grant_div = div_full;
      end
    end
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = '0;
    if (pipe_wen) begin
      wr_en   = (pipe_rd != 5'd0);
      wr_rd   = pipe_rd;
      wr_data = pipe_data;
    end else if (grant_mul) begin
      wr_en   = (mul_rd_q != 5'd0);
      wr_rd   = mul_rd_q;
      wr_data = mul_data_q;
    end else if (grant_div) begin
      wr_en   = (div_rd_q != 5'd0);
      wr_rd   = div_rd_q;
      wr_data = div_data_q;
    end
  end

  // Next scoreboard, unit ownership and starvation counts; drains clear before issues set
  always_comb begin
    busy_nxt      = busy_mask;
    unit_busy_nxt = unit_busy;
    if (grant_mul) begin
      busy_nxt[mul_rd_q] = 1'b0;
      unit_busy_nxt[0]   = 1'b0;
    end
    if (grant_div) begin
      busy_nxt[div_rd_q] = 1'b0;
      unit_busy_nxt[1]   = 1'b0;
    end
    if (iss_fire) begin
      unit_busy_nxt[iss_unit] = 1'b1;
      if (iss_rd != 5'd0) busy_nxt[iss_rd] = 1'b1;
    end
    mul_cnt_nxt = mul_cnt;
    if (grant_mul) mul_cnt_nxt = '0;
    else if (mul_full && mul_cnt != STARVE_MAX) mul_cnt_nxt = mul_cnt + CW'(1);
    div_cnt_nxt = div_cnt;
    if (grant_div) div_cnt_nxt = '0;
    else if (div_full && div_cnt != STARVE_MAX) div_cnt_nxt = div_cnt + CW'(1);
  end

  // Register the write port, scoreboard, arbitration pointer and stall request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen    <= 1'b0;
      rf_rd     <= 5'd0;
      rf_data   <= '0;
      busy_mask <= 32'd0;
      unit_busy <= 2'b00;
      rr        <= 1'b0;
      mul_cnt   <= '0;
      div_cnt   <= '0;
      stall_req <= 1'b0;
    end else begin
      rf_wen    <= wr_en;
      rf_rd     <= wr_rd;
      rf_data   <= wr_data;
      busy_mask <= busy_nxt;
      unit_busy <= unit_busy_nxt;
      if (grant_mul && div_full) rr <= 1'b1;
      else if (grant_div && mul_full) rr <= 1'b0;
      mul_cnt   <= mul_cnt_nxt;
      div_cnt   <= div_cnt_nxt;
      stall_req <= (mul_cnt_nxt == STARVE_MAX) || (div_cnt_nxt == STARVE_MAX);
    end
  end

  // One-entry result buffers: load on accept, empty on grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_full   <= 1'b0;
      mul_rd_q   <= 5'd0;
      mul_data_q <= '0;
      div_full   <= 1'b0;
      div_rd_q   <= 5'd0;
      div_data_q <= '0;
    end else begin
      if (grant_mul) begin
        mul_full <= 1'b0;
      end else if (mul_valid && !mul_full) begin
        mul_full   <= 1'b1;
        mul_rd_q   <= mul_rd;
        mul_data_q <= mul_result;
      end
      if (grant_div) begin
        div_full <= 1'b0;
      end else if (div_valid && !div_full) begin
        div_full   <= 1'b1;
        div_rd_q   <= div_rd;
        div_data_q <= div_result;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220066_wb_arbiter.sv
// tb/tb_ysyx_220066_wb_arbiter.sv - directed scoreboard bench for the writeback arbiter
module tb_ysyx_220066_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk, rst;
  logic            pipe_wen;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            iss_valid, iss_unit, iss_ready;
  logic [4:0]      iss_rd;
  logic            mul_valid, mul_ready;
  logic [4:0]      mul_rd;
  logic [XLEN-1:0] mul_result;
  logic            div_valid, div_ready;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] div_result;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic [31:0]     busy_mask;
  logic            stall_req;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  stall_at;

  ysyx_220066_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .iss_valid(iss_valid), .iss_unit(iss_unit), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_result(mul_result), .mul_ready(mul_ready),
    .div_valid(div_valid), .div_rd(div_rd), .div_result(div_result), .div_ready(div_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
    .busy_mask(busy_mask), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic void push(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Advance one clock; every RF write seen must match the scoreboard head
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, rf_wen}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rd", {59'd0, rf_rd}, {59'd0, e.rd});
        chk("sb_data", rf_data, e.data);
      end
    end
  endtask

  task automatic issue(input logic unit, input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_unit  = unit;
    iss_rd    = rd;
    #1;
    chk("iss_ready", {63'd0, iss_ready}, 64'd1);
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
    iss_valid = 0; iss_unit = 0; iss_rd = 0;
    mul_valid = 0; mul_rd = 0; mul_result = 0;
    div_valid = 0; div_rd = 0; div_result = 0;
    stall_at = -1;
    tick();
    tick();
    chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
    chk("rst_rf_data", rf_data, 64'd0);
    chk("rst_busy", {32'd0, busy_mask}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_mul_ready", {63'd0, mul_ready}, 64'd1);
    chk("rst_div_ready", {63'd0, div_ready}, 64'd1);
    rst = 1'b1;
    tick();

    // single mul completion, WAW-blocked div issue
    issue(1'b0, 5'd5);
    chk("busy_after_issue", {32'd0, busy_mask}, 64'h20);
    iss_valid = 1'b1; iss_unit = 1'b1; iss_rd = 5'd5;
    #1;
    chk("iss_ready_waw", {63'd0, iss_ready}, 64'd0);
    tick();
    iss_valid = 1'b0;
    chk("busy_rejected", {32'd0, busy_mask}, 64'h20);
    mul_valid = 1'b1; mul_rd = 5'd5; mul_result = 64'h1234;
    push(5'd5, 64'h1234);
    tick();
    mul_valid = 1'b0;
    chk("mul_ready_full", {63'd0, mul_ready}, 64'd0);
    chk("no_write_on_accept", {63'd0, rf_wen}, 64'd0);
    tick();
    chk("mul_wen", {63'd0, rf_wen}, 64'd1);
    chk("mul_rd", {59'd0, rf_rd}, 64'd5);
    chk("mul_data", rf_data, 64'h1234);
    chk("busy_cleared", {32'd0, busy_mask}, 64'd0);
    iss_unit = 1'b1; iss_rd = 5'd5;
    #1;
    chk("iss_ready_after_drain", {63'd0, iss_ready}, 64'd1);

    // simultaneous completions: mul first, then rr favours div
    issue(1'b0, 5'd3);
    issue(1'b1, 5'd4);
    mul_valid = 1'b1; mul_rd = 5'd3; mul_result = 64'hAAAA;
    div_valid = 1'b1; div_rd = 5'd4; div_result = 64'hBBBB;
    push(5'd3, 64'hAAAA);
    push(5'd4, 64'hBBBB);
    tick();
    mul_valid = 1'b0; div_valid = 1'b0;
    tick();
    chk("rr1_first", {59'd0, rf_rd}, 64'd3);
    tick();
    chk("rr1_second", {59'd0, rf_rd}, 64'd4);
    issue(1'b0, 5'd3);
    issue(1'b1, 5'd4);
    mul_valid = 1'b1; mul_rd = 5'd3; mul_result = 64'hCCCC;
    div_valid = 1'b1; div_rd = 5'd4; div_result = 64'hDDDD;
    push(5'd4, 64'hDDDD);
    push(5'd3, 64'hCCCC);
    tick();
    mul_valid = 1'b0; div_valid = 1'b0;
    tick();
    chk("rr2_first", {59'd0, rf_rd}, 64'd4);
    tick();
    chk("rr2_second", {59'd0, rf_rd}, 64'd3);
    chk("busy_after_rr", {32'd0, busy_mask}, 64'd0);

    // starvation under continuous pipeline writes
    issue(1'b1, 5'd7);
    for (int i = 0; i < 10; i++) begin
      pipe_wen = 1'b1; pipe_rd = 5'd10; pipe_data = 64'h100 + 64'(i);
      chk("pipe_waw", {63'd0, busy_mask[pipe_rd]}, 64'd0);
      push(5'd10, 64'h100 + 64'(i));
      if (i == 0) begin
        div_valid = 1'b1; div_rd = 5'd7; div_result = 64'h7777;
      end
      tick();
      div_valid = 1'b0;
      if (stall_req === 1'b1) begin
        stall_at = i;
        break;
      end
    end
    chk("stall_at", 64'(stall_at), 64'd4);
    pipe_wen = 1'b0;
    push(5'd7, 64'h7777);
    tick();
    chk("starve_drain_wen", {63'd0, rf_wen}, 64'd1);
    chk("starve_drain_rd", {59'd0, rf_rd}, 64'd7);
    tick();
    chk("stall_released", {63'd0, stall_req}, 64'd0);
    chk("busy_after_starve", {32'd0, busy_mask}, 64'd0);

    // rd=0 completion frees the divider without writing
    issue(1'b1, 5'd0);
    chk("busy_rd0", {32'd0, busy_mask}, 64'd0);
    iss_unit = 1'b1; iss_rd = 5'd1;
    #1;
    chk("div_unit_busy", {63'd0, iss_ready}, 64'd0);
    div_valid = 1'b1; div_rd = 5'd0; div_result = 64'hDEAD;
    tick();
    div_valid = 1'b0;
    chk("div_ready_full", {63'd0, div_ready}, 64'd0);
    tick();
    chk("rd0_no_write", {63'd0, rf_wen}, 64'd0);
    chk("div_ready_back", {63'd0, div_ready}, 64'd1);
    chk("div_iss_restored", {63'd0, iss_ready}, 64'd1);

    // back-to-back multiplier results to the same register
    issue(1'b0, 5'd9);
    mul_valid = 1'b1; mul_rd = 5'd9; mul_result = 64'h9999;
    push(5'd9, 64'h9999);
    tick();
    mul_valid = 1'b0;
    tick();
    chk("b2b_first", {59'd0, rf_rd}, 64'd9);
    issue(1'b0, 5'd9);
    mul_valid = 1'b1; mul_rd = 5'd9; mul_result = 64'h9A9A;
    push(5'd9, 64'h9A9A);
    tick();
    mul_valid = 1'b0;
    tick();
    chk("b2b_second", rf_data, 64'h9A9A);
    repeat (3) tick();
    chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("b2b_busy", {32'd0, busy_mask}, 64'd0);

    // asynchronous reset with both buffers full discards both results
    issue(1'b0, 5'd12);
    issue(1'b1, 5'd13);
    mul_valid = 1'b1; mul_rd = 5'd12; mul_result = 64'h1212;
    div_valid = 1'b1; div_rd = 5'd13; div_result = 64'h1313;
    tick();
    mul_valid = 1'b0; div_valid = 1'b0;
    iss_unit = 1'b0; iss_rd = 5'd12;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", {32'd0, busy_mask}, 64'd0);
    chk("async_rst_mul_ready", {63'd0, mul_ready}, 64'd1);
    chk("async_rst_div_ready", {63'd0, div_ready}, 64'd1);
    tick();
    chk("rst_edge_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_edge_busy", {32'd0, busy_mask}, 64'd0);
    chk("rst_edge_iss_ready", {63'd0, iss_ready}, 64'd1);
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_wen", {63'd0, rf_wen}, 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
